core_bus_responder: RTL and testbench
=====================================

# core_bus_responder

Memory-side responder for the core's two bus initiators: the instruction prefetch port and the data load/store port. It accepts both access/ack handshakes and arbitrates them round-robin onto a single synchronous SRAM port. Data-port I/O cycles are steered to a separate I/O port with open-ended latency. It sits between the CPU top level and on-chip RAM and peripherals, and completes every access with a one-cycle ack.

## Interface
Parameters:
- WAIT_STATES, default 0: extra cycles inserted before ack on every SRAM access (0..15).

Ports:
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high
- instr_m_addr  in  19  instruction word address [19:1]
- instr_m_access  in  1  instruction request, held until ack
- instr_m_ack  out  1  one-cycle completion pulse
- instr_m_data_in  out  16  instruction read data, valid with ack
- data_m_addr  in  19  data word address [19:1]
- data_m_data_out  in  16  write data from core
- data_m_access  in  1  data request, held until ack
- data_m_wr_en  in  1  1 = write
- data_m_bytesel  in  2  byte enables {hi, lo}
- d_io  in  1  1 = I/O cycle, 0 = memory
- data_m_ack  out  1  one-cycle completion pulse
- data_m_data_in  out  16  data read result, valid with ack
- mem_addr  out  19  SRAM word address
- mem_cs  out  1  SRAM select, one cycle per access
- mem_we  out  1  SRAM write strobe, qualified by mem_cs
- mem_be  out  2  SRAM byte enables
- mem_wdata  out  16  SRAM write data
- mem_rdata  in  16  SRAM read data, valid the cycle after mem_cs
- io_addr  out  15  I/O port address [15:1]
- io_rd / io_wr  out  1 each  I/O strobes, held until io_ack
- io_wdata  out  16  I/O write data
- io_be  out  2  I/O byte enables
- io_rdata  in  16  I/O read data, valid with io_ack
- io_ack  in  1  I/O completion

## Operation
- States: IDLE, MEM, CAPTURE, WAIT, IO, ACK.
- IDLE: sample both access lines and choose a grant:
  - One requester pending: grant it.
  - Both pending: grant the port not granted last. last_grant resets to INSTR, so the first tie goes to DATA.
  - On grant, register address, byte enables, write data and wr_en.
  - Next state is IO if the data port is granted with d_io=1, otherwise MEM.
- Instruction port: always a read with byte enables 2'b11. It never produces an I/O cycle.
- MEM: mem_cs=1 for exactly one cycle; mem_we=wr_en. Go to CAPTURE.
- CAPTURE: on reads, load mem_rdata into the granted port's read-data register. On writes, leave the read-data register unchanged. Go to WAIT if WAIT_STATES>0 (load the counter), otherwise ACK.
- WAIT: decrement the counter; go to ACK when it reaches 1.
- IO: hold io_rd or io_wr until io_ack. On io_ack, capture io_rdata for reads, drop the strobe and go to ACK.
- ACK: pulse the granted port's ack for one cycle, update last_grant, return to IDLE.
- Read-data registers hold their value until the next read completes on that port.
- Initiators drop access on the edge where they sample ack. A request seen high in IDLE is therefore always a new request.

## Timing
- SRAM access: ack is high in cycle 3+WAIT_STATES, counting the IDLE cycle where the request is first seen as cycle 0. With WAIT_STATES=0: cycle 1 mem_cs, cycle 3 ack.
- I/O access: strobe rises in cycle 1. Ack comes in the cycle after the io_ack cycle.
- Throughput: back-to-back accesses on alternating ports, one every 4+WAIT_STATES cycles.
- Simultaneous events:
  - A request arriving during a busy transaction waits and is sampled in the next IDLE.
  - Both ports never receive ack in the same cycle.
- Reset values: every output 0, including both read-data registers, io strobes and mem_cs; state IDLE; last_grant INSTR.
- Reset mid-transaction: abort, return to IDLE next cycle, emit no ack, deassert io strobes immediately. The I/O device must tolerate an abandoned strobe.

## Structure
- Package core_bus_responder_pkg holds:
  - the state enum
  - grant_t (GRANT_INSTR, GRANT_DATA)
  - WAIT_CNT_BITS = 4
- Sub-module rr_arbiter2: a two-way round-robin arbiter with req[1:0], an update strobe, and a registered last-grant. It is reusable for future DMA ports.
- Everything else lives in one FSM module.

## Test plan
- Instruction read, WAIT_STATES=0: addr 0x00010, mem_rdata=0xBEEF -> mem_cs in cycle 1, instr_m_ack in cycle 3, instr_m_data_in=0xBEEF.
- Data byte write: addr 0x00020, bytesel=2'b10, data 0x12AB -> mem_we=1, mem_be=2'b10, mem_wdata=0x12AB; data_m_ack in cycle 3; data_m_data_in unchanged.
- Simultaneous requests from reset, both held -> data acked first, instruction next; repeat with new requests -> order alternates and neither port starves.
- I/O read: d_io=1, addr 0x0060>>1, io_ack 5 cycles after io_rd with io_rdata=0x00FA -> data_m_ack the cycle after io_ack, data_m_data_in=0x00FA, no mem_cs.
- WAIT_STATES=3 instruction read -> ack in cycle 6.
- Reset asserted in the CAPTURE cycle -> no ack, all outputs 0 next cycle, and a fresh request completes normally.

Source files
------------

// File: rtl/core_bus_responder_pkg.sv
// Shared types and constants for the core bus responder: FSM state
// encodings, grant identifiers and wait-state counter width.
package core_bus_responder_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MEM     = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_IO      = 3'd4;
  localparam logic [2:0] ST_ACK     = 3'd5;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  localparam int WAIT_CNT_BITS = 4;

endpackage

// File: rtl/core_bus_responder_if.sv
// Bus bundle between the core initiators, the responder, the SRAM and the
// I/O port. The responder uses the slave view; the core side uses master.
interface core_bus_responder_if;

  logic [18:0] instr_m_addr;
  logic        instr_m_access;
  logic        instr_m_ack;
  logic [15:0] instr_m_data_in;

  logic [18:0] data_m_addr;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic        d_io;
  logic        data_m_ack;
  logic [15:0] data_m_data_in;

  logic [18:0] mem_addr;
  logic        mem_cs;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [14:0] io_addr;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_wdata;
  logic [1:0]  io_be;
  logic [15:0] io_rdata;
  logic        io_ack;

  modport slave (
    input  instr_m_addr, instr_m_access,
    output instr_m_ack, instr_m_data_in,
    input  data_m_addr, data_m_data_out, data_m_access, data_m_wr_en,
    input  data_m_bytesel, d_io,
    output data_m_ack, data_m_data_in,
    output mem_addr, mem_cs, mem_we, mem_be, mem_wdata,
    input  mem_rdata,
    output io_addr, io_rd, io_wr, io_wdata, io_be,
    input  io_rdata, io_ack
  );

  modport master (
    output instr_m_addr, instr_m_access,
    input  instr_m_ack, instr_m_data_in,
    output data_m_addr, data_m_data_out, data_m_access, data_m_wr_en,
    output data_m_bytesel, d_io,
    input  data_m_ack, data_m_data_in,
    input  mem_addr, mem_cs, mem_we, mem_be, mem_wdata,
    output mem_rdata,
    input  io_addr, io_rd, io_wr, io_wdata, io_be,
    output io_rdata, io_ack
  );

endinterface

// File: rtl/core_bus_responder_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not served last wins.
// The last-served index is recorded only when the owner strobes update.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic [1:0] gnt
);

  logic last;

  // NOTE: every path assigns gnt (default first), so no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b0;
    end else if (update) begin
      last <= served;
    end
  end

endmodule

// File: rtl/core_bus_responder.sv
// Responder for the instruction and data initiators: round-robin arbitration
// onto one synchronous SRAM port, with data-port I/O cycles steered to io_*.
module core_bus_responder
  import core_bus_responder_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input logic                  clk,
  input logic                  reset,
  core_bus_responder_if.slave  bus
);

  logic [2:0]               state;
  grant_t                   grant_q;
  grant_t                   pick;
  logic [18:0]              addr_q;
  logic [1:0]               be_q;
  logic [15:0]              wdata_q;
  logic                     wr_q;
  logic [WAIT_CNT_BITS-1:0] wait_cnt;
  logic [15:0]              instr_rdata_q;
  logic [15:0]              data_rdata_q;
  logic [1:0]               req;
  logic [1:0]               arb_gnt;

  assign req  = {bus.data_m_access, bus.instr_m_access};
  assign pick = arb_gnt[1] ? GRANT_DATA : GRANT_INSTR;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (state == ST_ACK),
    .served (grant_q),
    .gnt    (arb_gnt)
  );

  // NOTE: the read-data holding registers are reset too, so both ports read 0 out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      grant_q       <= GRANT_INSTR;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      wr_q          <= 1'b0;
      wait_cnt      <= '0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant_q <= pick;
            if (pick == GRANT_DATA) begin
              addr_q  <= bus.data_m_addr;
              be_q    <= bus.data_m_bytesel;
              wdata_q <= bus.data_m_data_out;
              wr_q    <= bus.data_m_wr_en;
              state   <= bus.d_io ? ST_IO : ST_MEM;
            end else begin
              // Instruction fetches are always full-word reads.
              addr_q  <= bus.instr_m_addr;
              be_q    <= 2'b11;
              wdata_q <= '0;
              wr_q    <= 1'b0;
              state   <= ST_MEM;
            end
          end
        end
        ST_MEM: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          if (!wr_q) begin
            if (grant_q == GRANT_DATA) data_rdata_q <= bus.mem_rdata;
            else                       instr_rdata_q <= bus.mem_rdata;
          end
          if (WAIT_STATES > 0) begin
            wait_cnt <= WAIT_CNT_BITS'(WAIT_STATES);
            state    <= ST_WAIT;
          end else begin
            state <= ST_ACK;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt <= 1) state <= ST_ACK;
        end
        ST_IO: begin
          if (bus.io_ack) begin
            if (!wr_q) data_rdata_q <= bus.io_rdata;
            state <= ST_ACK;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_cs    = (state == ST_MEM);
  assign bus.mem_we    = (state == ST_MEM) && wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

  // Strobes drop in the reset cycle itself so an aborted I/O cycle ends at once.
  assign bus.io_rd    = (state == ST_IO) && !wr_q && !reset;
  assign bus.io_wr    = (state == ST_IO) &&  wr_q && !reset;
  assign bus.io_addr  = addr_q[14:0];
  assign bus.io_wdata = wdata_q;
  assign bus.io_be    = be_q;

  assign bus.instr_m_ack     = (state == ST_ACK) && (grant_q == GRANT_INSTR);
  assign bus.data_m_ack      = (state == ST_ACK) && (grant_q == GRANT_DATA);
  assign bus.instr_m_data_in = instr_rdata_q;
  assign bus.data_m_data_in  = data_rdata_q;

endmodule

// File: tb/tb_core_bus_responder.sv
// Directed bench for core_bus_responder: one instance with no wait states,
// one with three. Inputs change and outputs are sampled on the falling edge.
module tb_core_bus_responder;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [18:0] i_addr;
  logic [18:0] d_addr;
  logic        exp_d;

  core_bus_responder_if bus0 ();
  core_bus_responder_if bus1 ();

  core_bus_responder #(.WAIT_STATES(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  core_bus_responder #(.WAIT_STATES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus0.instr_m_addr = '0; bus0.instr_m_access = 0;
    bus0.data_m_addr = '0; bus0.data_m_data_out = '0; bus0.data_m_access = 0;
    bus0.data_m_wr_en = 0; bus0.data_m_bytesel = 2'b11; bus0.d_io = 0;
    bus0.mem_rdata = '0; bus0.io_rdata = '0; bus0.io_ack = 0;
    bus1.instr_m_addr = '0; bus1.instr_m_access = 0;
    bus1.data_m_addr = '0; bus1.data_m_data_out = '0; bus1.data_m_access = 0;
    bus1.data_m_wr_en = 0; bus1.data_m_bytesel = 2'b11; bus1.d_io = 0;
    bus1.mem_rdata = '0; bus1.io_rdata = '0; bus1.io_ack = 0;
    tick(); tick();

    // Reset state
    check("rst_mem_cs", bus0.mem_cs, 0);
    check("rst_iack", bus0.instr_m_ack, 0);
    check("rst_dack", bus0.data_m_ack, 0);
    check("rst_io_strobes", {bus0.io_rd, bus0.io_wr}, 0);
    check("rst_rdata", {bus0.instr_m_data_in, bus0.data_m_data_in}, 0);
    check("rst_mem_addr_be", {bus0.mem_addr, bus0.mem_be}, 0);
    reset = 1'b0;

    // Instruction read, no wait states
    bus0.instr_m_addr = 19'h00010; bus0.instr_m_access = 1; bus0.mem_rdata = 16'hBEEF;
    tick();
    check("ird_c1_cs", bus0.mem_cs, 1);
    check("ird_c1_we", bus0.mem_we, 0);
    check("ird_c1_addr", bus0.mem_addr, 19'h00010);
    check("ird_c1_be", bus0.mem_be, 2'b11);
    tick();
    check("ird_c2_ack", bus0.instr_m_ack, 0);
    tick();
    check("ird_c3_ack", bus0.instr_m_ack, 1);
    check("ird_c3_dack", bus0.data_m_ack, 0);
    check("ird_c3_data", bus0.instr_m_data_in, 16'hBEEF);
    bus0.instr_m_access = 0;
    tick();
    check("ird_c4_ack", bus0.instr_m_ack, 0);

    // Data byte write: read-data register must not change
    bus0.data_m_addr = 19'h00020; bus0.data_m_bytesel = 2'b10; bus0.data_m_data_out = 16'h12AB;
    bus0.data_m_wr_en = 1; bus0.data_m_access = 1; bus0.mem_rdata = 16'h5555;
    tick();
    check("dwr_c1_cs_we", {bus0.mem_cs, bus0.mem_we}, 2'b11);
    check("dwr_c1_be", bus0.mem_be, 2'b10);
    check("dwr_c1_wdata", bus0.mem_wdata, 16'h12AB);
    check("dwr_c1_addr", bus0.mem_addr, 19'h00020);
    tick(); tick();
    check("dwr_c3_ack", {bus0.data_m_ack, bus0.instr_m_ack}, 2'b10);
    check("dwr_c3_data", bus0.data_m_data_in, 16'h0000);
    check("dwr_c3_idata", bus0.instr_m_data_in, 16'hBEEF);
    bus0.data_m_access = 0; bus0.data_m_wr_en = 0; bus0.data_m_bytesel = 2'b11;
    tick();

    // Fresh reset, then both ports request continuously: D, I, D, I
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_rdata", {bus0.instr_m_data_in, bus0.data_m_data_in}, 0);
    i_addr = 19'h00100; d_addr = 19'h00200;
    bus0.instr_m_addr = i_addr; bus0.data_m_addr = d_addr;
    bus0.instr_m_access = 1; bus0.data_m_access = 1;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      tick();
      bus0.mem_rdata = 16'hA000 | 16'(k);
      check($sformatf("rr%0d_cs", k), bus0.mem_cs, 1);
      check($sformatf("rr%0d_addr", k), bus0.mem_addr, exp_d ? d_addr : i_addr);
      tick(); tick();
      check($sformatf("rr%0d_acks", k), {bus0.data_m_ack, bus0.instr_m_ack}, exp_d ? 2'b10 : 2'b01);
      check($sformatf("rr%0d_rdata", k), exp_d ? bus0.data_m_data_in : bus0.instr_m_data_in,
            16'hA000 | 16'(k));
      if (k == 3) begin
        bus0.instr_m_access = 0; bus0.data_m_access = 0;
      end else if (exp_d) begin
        bus0.data_m_access = 0;
      end else begin
        bus0.instr_m_access = 0;
      end
      tick();
      if (k < 3) begin
        if (exp_d) begin
          d_addr = d_addr + 1; bus0.data_m_addr = d_addr; bus0.data_m_access = 1;
        end else begin
          i_addr = i_addr + 1; bus0.instr_m_addr = i_addr; bus0.instr_m_access = 1;
        end
      end
    end

    // I/O read, io_ack five cycles after io_rd rises
    bus0.d_io = 1; bus0.data_m_addr = 19'h00030; bus0.data_m_wr_en = 0;
    bus0.data_m_bytesel = 2'b11; bus0.data_m_access = 1;
    tick();
    check("io_c1_strobes", {bus0.io_rd, bus0.io_wr}, 2'b10);
    check("io_c1_cs", bus0.mem_cs, 0);
    check("io_c1_addr", bus0.io_addr, 15'h0030);
    for (int j = 2; j <= 5; j++) begin
      tick();
      check($sformatf("io_c%0d_hold", j), {bus0.io_rd, bus0.data_m_ack, bus0.mem_cs}, 3'b100);
    end
    tick();
    bus0.io_ack = 1; bus0.io_rdata = 16'h00FA;
    check("io_c6_rd", bus0.io_rd, 1);
    tick();
    bus0.io_ack = 0;
    check("io_c7_ack", bus0.data_m_ack, 1);
    check("io_c7_data", bus0.data_m_data_in, 16'h00FA);
    check("io_c7_rd_cs", {bus0.io_rd, bus0.mem_cs}, 0);
    bus0.data_m_access = 0; bus0.d_io = 0;
    tick();

    // WAIT_STATES=3 instruction read: ack in cycle 6
    bus1.instr_m_addr = 19'h00055; bus1.instr_m_access = 1; bus1.mem_rdata = 16'h3C3C;
    tick();
    check("ws3_c1_cs", bus1.mem_cs, 1);
    tick(); tick(); tick(); tick();
    check("ws3_c5_ack", bus1.instr_m_ack, 0);
    tick();
    check("ws3_c6_ack", bus1.instr_m_ack, 1);
    check("ws3_c6_data", bus1.instr_m_data_in, 16'h3C3C);
    bus1.instr_m_access = 0;
    tick();

    // Reset sampled in the CAPTURE cycle aborts the access
    bus0.instr_m_addr = 19'h00077; bus0.instr_m_access = 1; bus0.mem_rdata = 16'h9999;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_acks", {bus0.instr_m_ack, bus0.data_m_ack}, 0);
    check("abort_cs", bus0.mem_cs, 0);
    check("abort_rdata", bus0.instr_m_data_in, 0);
    check("abort_addr_be", {bus0.mem_addr, bus0.mem_be}, 0);
    reset = 1'b0;
    bus0.instr_m_addr = 19'h00078; bus0.mem_rdata = 16'h4242;
    tick();
    check("post_c1_cs_addr", {bus0.mem_cs, bus0.mem_addr}, {1'b1, 19'h00078});
    tick(); tick();
    check("post_c3_ack", bus0.instr_m_ack, 1);
    check("post_c3_data", bus0.instr_m_data_in, 16'h4242);
    bus0.instr_m_access = 0;
    tick();
    check("post_c4_ack", bus0.instr_m_ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
